// File: rtl/alu_operand_stage.sv
// Issue stage in front of the 32-bit ALU: register file with writeback bypass,
// operand-B immediate select and a single-entry valid/ready slot driving a, b, f.
module alu_operand_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [$clog2(NREGS)-1:0] in_ra1,
  input  logic [$clog2(NREGS)-1:0] in_ra2,
  input  logic                     in_use_imm,
  input  logic [WIDTH-1:0]         in_imm,
  input  logic [2:0]               in_f,
  input  logic [$clog2(NREGS)-1:0] in_wa,
  input  logic                     wb_en,
  input  logic [$clog2(NREGS)-1:0] wb_addr,
  input  logic [WIDTH-1:0]         wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [2:0]               out_f,
  output logic [$clog2(NREGS)-1:0] out_wa,
  output logic [CNTW-1:0]          issue_count
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd1_c;
  logic [WIDTH-1:0] rd2_c;
  logic [WIDTH-1:0] opb_c;
  logic             accept_c;
  logic             xfer_c;
  logic             wb_wr_c;

  assign wb_wr_c  = wb_en && (wb_addr != AW'(0));
  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;
  assign xfer_c   = out_valid && out_ready;

  // Register file storage; r0 is never written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wb_wr_c) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Read ports forward same-cycle writeback data so a dependent op sees it
  always_comb begin
    rd1_c = '0;
    rd2_c = '0;
    if (in_ra1 != AW'(0)) begin
      rd1_c = (wb_wr_c && (wb_addr == in_ra1)) ? wb_data : regs[in_ra1];
    end
    if (in_ra2 != AW'(0)) begin
      rd2_c = (wb_wr_c && (wb_addr == in_ra2)) ? wb_data : regs[in_ra2];
    end
  end

  assign opb_c = in_use_imm ? in_imm : rd2_c;

  // Pipeline slot: operands are sampled only at accept and held while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_f     <= '0;
      out_wa    <= '0;
    end else if (accept_c) begin
      out_valid <= 1'b1;
      out_a     <= rd1_c;
      out_b     <= opb_c;
      out_f     <= in_f;
      out_wa    <= in_wa;
    end else if (xfer_c) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_count <= '0;
    end else if (xfer_c) begin
      issue_count <= issue_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed ops push expected operands,
// a negedge monitor pops and compares on each out transfer.
module tb_alu_operand_stage;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_ra1;
  logic [4:0]  in_ra2;
  logic        in_use_imm;
  logic [31:0] in_imm;
  logic [2:0]  in_f;
  logic [4:0]  in_wa;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [2:0]  out_f;
  logic [4:0]  out_wa;
  logic [15:0] issue_count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    logic [4:0]  wa;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   max_run = 0;
  logic [2:0] ftab [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

  alu_operand_stage #(.WIDTH(32), .NREGS(32), .CNTW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ra1(in_ra1), .in_ra2(in_ra2), .in_use_imm(in_use_imm),
    .in_imm(in_imm), .in_f(in_f), .in_wa(in_wa),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_f(out_f), .out_wa(out_wa),
    .issue_count(issue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every out transfer must match the oldest pending expectation
  always @(negedge clk) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got a=%h b=%h with nothing expected", out_a, out_b);
        end else begin
          mon_e = sbq.pop_front();
          check("out_a", out_a, mon_e.a);
          check("out_b", out_b, mon_e.b);
          check("out_f", 32'(out_f), 32'(mon_e.f));
          check("out_wa", 32'(out_wa), 32'(mon_e.wa));
        end
      end else begin
        run_len = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic ui,
                       input logic [31:0] imm, input logic [2:0] f, input logic [4:0] wa,
                       input logic [31:0] ea, input logic [31:0] eb);
    int n;
    exp_t e;
    n = 0;
    in_valid = 1'b1; in_ra1 = a1; in_ra2 = a2; in_use_imm = ui;
    in_imm = imm; in_f = f; in_wa = wa;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        errors++;
        $display("FAIL issue_timeout: got in_ready=0 for %0d cycles expected 1", n);
        in_valid = 1'b0;
        return;
      end
    end
    e.a = ea; e.b = eb; e.f = f; e.wa = wa;
    sbq.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    wb_en = 1'b1; wb_addr = addr; wb_data = data;
    @(posedge clk); #1;
    wb_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic drain();
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_ra1 = '0; in_ra2 = '0; in_use_imm = 1'b0;
    in_imm = '0; in_f = '0; in_wa = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_a", out_a, 32'd0);
    check("rst_out_b", out_b, 32'd0);
    check("rst_out_f", 32'(out_f), 32'd0);
    check("rst_out_wa", 32'(out_wa), 32'd0);
    check("rst_count", 32'(issue_count), 32'd0);
    do_reset();

    // Basic sub with register operands
    wb_write(5'd1, 32'h0000_0007);
    wb_write(5'd2, 32'hFFFF_FFFF);
    out_ready = 1'b1;
    issue(5'd1, 5'd2, 1'b0, 32'h0, 3'b110, 5'd4, 32'h0000_0007, 32'hFFFF_FFFF);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    drain();
    check("basic_count", 32'(issue_count), 32'd1);
    check("basic_idle_valid", 32'(out_valid), 32'd0);

    // Same-cycle writeback bypass, including r0
    wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    issue(5'd3, 5'd3, 1'b0, 32'h0, 3'b010, 5'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    issue(5'd0, 5'd0, 1'b0, 32'h0, 3'b010, 5'd6, 32'h0, 32'h0);
    wb_en = 1'b0;
    issue(5'd0, 5'd3, 1'b0, 32'h0, 3'b001, 5'd7, 32'h0, 32'hDEAD_BEEF);

    // Immediate replaces operand B
    wb_write(5'd5, 32'h0000_1234);
    issue(5'd5, 5'd5, 1'b1, 32'hFFFF_FFF0, 3'b000, 5'd8, 32'h0000_1234, 32'hFFFF_FFF0);
    drain();
    check("imm_count", 32'(issue_count), 32'd5);

    // Backpressure: stall three cycles while overwriting the captured source
    out_ready = 1'b0;
    issue(5'd1, 5'd2, 1'b0, 32'h0, 3'b001, 5'd9, 32'h0000_0007, 32'hFFFF_FFFF);
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'hAAAA_5555;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_out_a", out_a, 32'h0000_0007);
      check("stall_out_b", out_b, 32'hFFFF_FFFF);
      check("stall_count", 32'(issue_count), 32'd5);
      @(posedge clk); #1;
    end
    wb_en = 1'b0;
    out_ready = 1'b1;
    drain();
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_count", 32'(issue_count), 32'd6);
    issue(5'd1, 5'd0, 1'b0, 32'h0, 3'b010, 5'd10, 32'hAAAA_5555, 32'h0);
    drain();

    // Back-to-back at full throughput
    do_reset();
    out_ready = 1'b1;
    wb_write(5'd1, 32'h1111_1111);
    max_run = 0;
    for (int i = 0; i < 8; i++) begin
      issue(5'd1, 5'd0, 1'b1, 32'(100 + i), ftab[i % 5], 5'(i), 32'h1111_1111, 32'(100 + i));
    end
    drain();
    check("b2b_count", 32'(issue_count), 32'd8);
    check("b2b_run", 32'(max_run), 32'd8);

    // Counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      issue(5'd0, 5'd0, 1'b1, 32'(i), 3'b010, 5'(i), 32'h0, 32'(i));
    end
    drain();
    check("pre_wrap_count", 32'(issue_count), 32'h0000_FFFF);
    issue(5'd0, 5'd0, 1'b1, 32'hCAFE_0001, 3'b111, 5'd31, 32'h0, 32'hCAFE_0001);
    drain();
    check("wrap_count", 32'(issue_count), 32'h0000_0000);

    // Asynchronous reset with a held slot
    wb_write(5'd2, 32'h0000_0005);
    out_ready = 1'b0;
    issue(5'd2, 5'd2, 1'b0, 32'h0, 3'b010, 5'd3, 32'h5, 32'h5);
    @(negedge clk);
    check("held_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_out_a", out_a, 32'd0);
    check("async_count", 32'(issue_count), 32'd0);
    sbq.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    issue(5'd2, 5'd2, 1'b0, 32'h0, 3'b110, 5'd1, 32'h0, 32'h0);
    drain();
    check("post_rst_count", 32'(issue_count), 32'd1);

    check("sb_empty", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Issue stage directly upstream of the 32-bit ALU (ports a, b, f[2:0]).
- Holds the 2-read/1-write register file and selects operand B from a register or an immediate.
- Bypasses same-cycle writeback data and registers the operands into a single-entry valid/ready pipeline slot.
- Slot outputs drive the ALU a, b and f inputs directly; the ALU result returns through the writeback port.

Parameters:
WIDTH, 32, datapath width of operands, immediate and writeback data
NREGS, 32, register count; address width is $clog2(NREGS) = 5
CNTW, 16, width of the issued-operation counter

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  upstream operation valid
in_ready  out  1  stage can accept an operation this cycle
in_ra1  in  5  register address for operand A
in_ra2  in  5  register address for operand B
in_use_imm  in  1  1: operand B = in_imm; 0: operand B = reg[in_ra2]
in_imm  in  WIDTH  pre-sign-extended immediate
in_f  in  3  ALU control (010 add, 110 sub, 000 and, 001 or, 111 slt)
in_wa  in  5  destination register, carried alongside
wb_en  in  1  writeback enable
wb_addr  in  5  writeback register address
wb_data  in  WIDTH  writeback data (ALU y)
out_valid  out  1  operands valid toward the ALU
out_ready  in  1  downstream consumes the slot
out_a  out  WIDTH  ALU a
out_b  out  WIDTH  ALU b
out_f  out  3  ALU f
out_wa  out  5  destination register
issue_count  out  CNTW  number of completed out transfers

Behaviour:
- Reset (reset_n=0, asynchronous): all NREGS registers=0; out_valid=0; out_a=0; out_b=0; out_f=0; out_wa=0; issue_count=0. in_ready=1 immediately, since it is derived from out_valid.
- Reset mid-operation: a held slot is discarded; no transfer is counted.
- Register file:
  - Write at posedge when wb_en=1 and wb_addr!=0.
  - Register 0 always reads 0; writes to it are ignored.
- Read path is combinational, with bypass:
  - If wb_en=1, wb_addr==ra and ra!=0, the read returns wb_data; otherwise the stored value.
  - Bypass applies to both ports independently.
- Operand B = in_use_imm ? in_imm : read2. in_ra2 is ignored when in_use_imm=1.
- Handshake:
  - in_ready = !out_valid | out_ready.
  - Accept = in_valid & in_ready. On accept, at posedge: capture a, b, in_f and in_wa into the slot; out_valid<=1.
  - Out transfer = out_valid & out_ready. On a transfer with no accept in the same cycle: out_valid<=0; data regs hold their old values.
  - Simultaneous transfer and accept: slot reloads with the new operation, out_valid stays 1 and the stage runs at full throughput.
- Latency: 1 cycle from accept to out_valid.
- While the slot is stalled (out_valid=1, out_ready=0):
  - out_a, out_b, out_f and out_wa are held stable.
  - A writeback to a register captured in the slot does NOT update it; operands are sampled at accept only.
- in_valid=0: no capture. Upstream may change inputs freely while in_ready=0.
- issue_count increments by 1 on every out transfer and wraps 0xFFFF -> 0x0000 silently.
- No combinational path from in_* to out_*. out_ready to in_ready is the only combinational path through the stage.

Test Plan:
- Reset, then write r1=0x00000007 and r2=0xFFFFFFFF through the writeback port. Issue ra1=1, ra2=2, f=110 with out_ready=1 -> next cycle out_valid=1, out_a=0x00000007, out_b=0xFFFFFFFF, out_f=110; issue_count=1 after the transfer.
- Bypass: wb_en=1, wb_addr=3, wb_data=0xDEADBEEF in the same cycle as an accept with ra1=3, ra2=3 -> out_a=out_b=0xDEADBEEF. Repeat with wb_addr=0 -> out_a=out_b=0, and a later read of r0 returns 0.
- Immediate: in_use_imm=1, in_imm=0xFFFFFFF0, ra2=5 (r5=0x1234) -> out_b=0xFFFFFFF0.
- Backpressure: hold out_ready=0 for 3 cycles after an accept, writing the captured source register meanwhile -> in_ready=0, outputs unchanged, no count. Release -> one transfer, then in_ready=1.
- Back-to-back: in_valid=1 and out_ready=1 for 8 cycles with distinct ops -> 8 consecutive out_valid cycles in order; issue_count=8.
- Wrap and async reset: preload issue_count to 0xFFFF and transfer once -> 0x0000. Assert reset_n=0 mid-cycle while out_valid=1 -> out_valid=0 before the next edge; registers read 0.
